// File: rtl/poly_coef_bank.sv
// Ping-pong coefficient store: two banks, one written while the other is read, with a zeroing sweep.
// Latency: reads return READ_LATENCY (1 or 2) clocks after re; addr_err one clock after the access.
// Backpressure: none; while the clear sweep runs (busy) we, re, swap and clear are ignored.
module poly_coef_bank #(
  parameter int    WIDTH          = 13,
  parameter int    DEPTH          = 757,
  parameter int    ADDR_BITS      = 10,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string RAM_STYLE      = "distributed"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  output logic                 busy,
  input  logic                 swap,
  output logic                 wr_bank,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 addr_err
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  // One extra bit so DEPTH == 2**ADDR_BITS still compares correctly.
  localparam logic [ADDR_BITS:0]   DEPTH_W   = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam state_t               RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic                 RST_BUSY  = (CLEAR_ON_RESET != 0);

  state_t               state;
  logic [ADDR_BITS-1:0] clr_cnt;

  (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] bank0 [DEPTH];
  (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] bank1 [DEPTH];

  logic             idle;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_ok;
  logic             rd_acc;
  logic [WIDTH-1:0] rd_word;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_dat;

  assign idle        = (state == IDLE);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_ok       = idle & we & wr_in_range;
  assign rd_acc      = idle & re;

  // Read bank is always the one not being written; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = wr_bank ? bank0[rd_addr] : bank1[rd_addr];
    end
  end

  // Control FSM: clear sweep counter, bank select and busy flag; clear beats swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      busy    <= RST_BUSY;
      clr_cnt <= '0;
      wr_bank <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end else if (swap) begin
            wr_bank <= ~wr_bank;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Bank storage: sweep zeroes both banks at once, otherwise write into the write bank.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      bank0[clr_cnt] <= '0;
      bank1[clr_cnt] <= '0;
    end else if (wr_ok) begin
      if (wr_bank) begin
        bank1[wr_addr] <= wr_data;
      end else begin
        bank0[wr_addr] <= wr_data;
      end
    end
  end

  // First read stage: captures the read word; data holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_acc;
      if (rd_acc) begin
        s1_dat <= rd_word;
      end
    end
  end

  // Address error pulse for any accepted access with an address at or beyond DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= idle & ((we & ~wr_in_range) | (re & ~rd_in_range));
    end
  end

  // Any READ_LATENCY other than 2 is treated as 1.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic             s2_vld;
      logic [WIDTH-1:0] s2_dat;

      // Optional output register stage; again holds data between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld <= 1'b0;
          s2_dat <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_dat <= s1_dat;
          end
        end
      end

      assign rd_valid = s2_vld;
      assign rd_data  = s2_dat;
    end else begin : g_lat1
      assign rd_valid = s1_vld;
      assign rd_data  = s1_dat;
    end
  endgenerate

endmodule

// File: tb/tb_poly_coef_bank.sv
// Bench for poly_coef_bank: two instances (read latency 1 and 2) share stimulus and a bank model.
module tb_poly_coef_bank;

  localparam int DEPTH = 757;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        swap = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [9:0]  rd_addr = '0;
  logic [12:0] wr_data = '0;

  logic        busy1, wb1, rdv1, err1;
  logic [12:0] rdd1;
  logic        busy2, wb2, rdv2, err2;
  logic [12:0] rdd2;

  int n_cmp = 0;
  int n_bad = 0;
  bit running = 1'b1;

  always #5 clk = ~clk;

  poly_coef_bank #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy1), .swap(swap), .wr_bank(wb1),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .re(re), .rd_addr(rd_addr),
    .rd_data(rdd1), .rd_valid(rdv1), .addr_err(err1)
  );

  poly_coef_bank #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy2), .swap(swap), .wr_bank(wb2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .re(re), .rd_addr(rd_addr),
    .rd_data(rdd2), .rd_valid(rdv2), .addr_err(err2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int bank [2][DEPTH];
  bit mbusy;
  int mcnt;
  bit mwb;
  bit e_err;
  bit v1; int d1;
  bit v2; int d2;
  bit pv; int pd;

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    int rv;
    if (!rst_n) begin
      mbusy = 1'b1; mcnt = 0; mwb = 1'b0; e_err = 1'b0;
      v1 = 1'b0; d1 = 0; v2 = 1'b0; d2 = 0; pv = 1'b0; pd = 0;
    end else begin
      acc = re && !mbusy;
      rv  = (rd_addr < DEPTH) ? bank[!mwb][rd_addr] : 0;
      // latency-2 result is the read captured one edge ago
      v2 = pv;
      if (pv) d2 = pd;
      pv = acc;
      if (acc) pd = rv;
      v1 = acc;
      if (acc) d1 = rv;
      e_err = (!mbusy && we && wr_addr >= DEPTH) || (acc && rd_addr >= DEPTH);
      if (mbusy) begin
        bank[0][mcnt] = 0;
        bank[1][mcnt] = 0;
        mcnt++;
        if (mcnt == DEPTH) mbusy = 1'b0;
      end else begin
        if (we && wr_addr < DEPTH) bank[mwb][wr_addr] = int'(wr_data);
        if (clear) begin
          mbusy = 1'b1;
          mcnt  = 0;
        end else if (swap) begin
          mwb = !mwb;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (running) begin
      chk("busy_l1", int'(busy1), int'(mbusy));
      chk("wr_bank_l1", int'(wb1), int'(mwb));
      chk("rd_valid_l1", int'(rdv1), int'(v1));
      chk("rd_data_l1", int'(rdd1), d1);
      chk("addr_err_l1", int'(err1), int'(e_err));
      chk("busy_l2", int'(busy2), int'(mbusy));
      chk("wr_bank_l2", int'(wb2), int'(mwb));
      chk("rd_valid_l2", int'(rdv2), int'(v2));
      chk("rd_data_l2", int'(rdd2), d2);
      chk("addr_err_l2", int'(err2), int'(e_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      re = 1'b1; rd_addr = 10'(i);
      tick();
    end
    re = 1'b0;
    tick();
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    // power-on reset and automatic sweep
    repeat (3) tick();
    chk("rst_busy", int'(busy1), 1);
    chk("rst_wr_bank", int'(wb1), 0);
    chk("rst_rd_valid", int'(rdv1), 0);
    chk("rst_rd_data", int'(rdd1), 0);
    chk("rst_addr_err", int'(err1), 0);
    rst_n = 1'b1;
    count_busy(n);
    chk("por_busy_cycles", n, 757);

    // both banks read zero after the sweep
    read_all();
    pulse_swap();
    tick();
    chk("swap_wr_bank", int'(wb1), 1);
    read_all();

    // fill bank 0 with data = addr, swap, read back
    pulse_swap();
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; wr_addr = 10'(i); wr_data = 13'(i);
      tick();
    end
    we = 1'b0;
    pulse_swap();
    read_all();
    tick();
    tick();
    chk("hold_l1", int'(rdd1), 756);
    chk("hold_l2", int'(rdd2), 756);
    chk("hold_rdv_l1", int'(rdv1), 0);

    // swap + write + read in the same cycle
    swap = 1'b1; we = 1'b1; wr_addr = 10'd10; wr_data = 13'd291; re = 1'b1; rd_addr = 10'd10;
    tick();
    swap = 1'b0; we = 1'b0; re = 1'b0;
    chk("same_cyc_wr_bank", int'(wb1), 0);
    chk("same_cyc_rd_l1", int'(rdd1), 10);
    chk("same_cyc_rdv_l1", int'(rdv1), 1);
    tick();
    chk("same_cyc_rd_l2", int'(rdd2), 10);
    re = 1'b1; rd_addr = 10'd10;
    tick();
    re = 1'b0;
    chk("old_bank_write_l1", int'(rdd1), 291);
    tick();

    // out-of-range write and read
    we = 1'b1; wr_addr = 10'd800; wr_data = 13'd8191;
    tick();
    we = 1'b0;
    chk("oob_wr_err", int'(err1), 1);
    tick();
    chk("oob_err_pulse", int'(err1), 0);
    re = 1'b1; rd_addr = 10'd10;
    tick();
    rd_addr = 10'd1000;
    tick();
    re = 1'b0;
    chk("oob_rd_data_l1", int'(rdd1), 0);
    chk("oob_rd_valid_l1", int'(rdv1), 1);
    chk("oob_rd_err", int'(err1), 1);
    tick();
    chk("oob_rd_err_pulse", int'(err1), 0);
    chk("oob_rd_data_l2", int'(rdd2), 0);
    chk("oob_rd_valid_l2", int'(rdv2), 1);
    pulse_swap();
    re = 1'b1; rd_addr = 10'd43;
    tick();
    rd_addr = 10'd288;
    tick();
    re = 1'b0;
    chk("no_alias_288", int'(rdd1), 288);
    tick();

    // clear with we/re/swap held high throughout
    clear = 1'b1; we = 1'b1; re = 1'b1; swap = 1'b1;
    wr_addr = 10'd5; wr_data = 13'd7; rd_addr = 10'd5;
    tick();
    clear = 1'b0;
    count_busy(n);
    we = 1'b0; re = 1'b0; swap = 1'b0;
    chk("clear_busy_cycles", n, 757);
    chk("clear_wr_bank_kept", int'(wb1), 1);
    read_all();
    pulse_swap();
    read_all();

    // reset in the middle of a sweep
    we = 1'b1; wr_addr = 10'd3; wr_data = 13'd99;
    tick();
    we = 1'b0;
    pulse_swap();
    re = 1'b1; rd_addr = 10'd3;
    tick();
    re = 1'b0;
    chk("pre_rst_data", int'(rdd1), 99);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    k = 0;
    while (mcnt != 300 && k < 2000) begin
      k++;
      tick();
    end
    chk("sweep_reached_300", mcnt, 300);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy1), 1);
    chk("mid_rst_wr_bank", int'(wb1), 0);
    chk("mid_rst_rd_data_l1", int'(rdd1), 0);
    chk("mid_rst_rd_data_l2", int'(rdd2), 0);
    chk("mid_rst_rd_valid", int'(rdv1), 0);
    chk("mid_rst_addr_err", int'(err1), 0);
    tick();
    rst_n = 1'b1;
    count_busy(n);
    chk("restart_busy_cycles", n, 757);
    re = 1'b1; rd_addr = 10'd3;
    tick();
    re = 1'b0;
    pulse_swap();
    re = 1'b1; rd_addr = 10'd3;
    tick();
    re = 1'b0;
    chk("after_restart_zero", int'(rdd1), 0);
    tick();
    tick();

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
